// File: rtl/data_mem_arbiter.sv
// Two-master arbiter in front of a single-port data memory.
// Every transfer takes three cycles (IDLE -> ACCESS -> RESP). The winner's
// payload is latched at arbitration, so later changes on the requester
// port cannot disturb a transfer that is already in flight.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0Req,
  input  logic              m0We,
  input  logic [ADDR_W-1:0] m0Addr,
  input  logic [DATA_W-1:0] m0WtData,
  output logic              m0Ack,
  output logic [DATA_W-1:0] m0RdData,

  input  logic              m1Req,
  input  logic              m1We,
  input  logic [ADDR_W-1:0] m1Addr,
  input  logic [DATA_W-1:0] m1WtData,
  output logic              m1Ack,
  output logic [DATA_W-1:0] m1RdData,

  output logic              memCe,
  output logic              memWr,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWtData,
  input  logic [DATA_W-1:0] memRdData,

  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;

  // Grant decision for the current IDLE cycle (1 = m1 wins)
  logic              any_req_c;
  logic              grant_m1_c;

  // Owner of the transfer in flight (1 = m1) and last-grant pointer
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;

  // Memory-side registers
  logic              ce_q, ce_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Requester-side registers
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic              busy_q, busy_d;

  // Arbitration: round-robin on ties, or fixed priority with m0 on top
  always_comb begin
    any_req_c  = m0Req | m1Req;
    grant_m1_c = 1'b0;
    if (PRIO_MODE != 0) begin
      grant_m1_c = ~m0Req & m1Req;
    end else if (m0Req && m1Req) begin
      grant_m1_c = ~last_grant_q;
    end else begin
      grant_m1_c = m1Req;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; everything holds unless a state acts on it
  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ce_d         = 1'b0;
    wr_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rd0_d        = rd0_q;
    rd1_d        = rd1_q;
    busy_d       = (state_d != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          owner_d      = grant_m1_c;
          last_grant_d = grant_m1_c;
          ce_d         = 1'b1;
          if (grant_m1_c) begin
            wr_d    = m1We;
            addr_d  = m1Addr;
            wdata_d = m1WtData;
          end else begin
            wr_d    = m0We;
            addr_d  = m0Addr;
            wdata_d = m0WtData;
          end
        end
      end
      ST_ACCESS: begin
        // Read data is taken at the end of ACCESS; writes leave RdData alone
        if (!wr_q) begin
          if (owner_q) begin
            rd1_d = memRdData;
          end else begin
            rd0_d = memRdData;
          end
        end
        if (owner_q) begin
          ack1_d = 1'b1;
        end else begin
          ack0_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers; reset clears them at once so an
  // aborted ACCESS cannot commit a write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ce_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rd0_q        <= '0;
      rd1_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      ce_q         <= ce_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rd0_q        <= rd0_d;
      rd1_q        <= rd1_d;
      busy_q       <= busy_d;
    end
  end

  assign memCe     = ce_q;
  assign memWr     = wr_q;
  assign memAddr   = addr_q;
  assign memWtData = wdata_q;
  assign m0Ack     = ack0_q;
  assign m1Ack     = ack1_q;
  assign m0RdData  = rd0_q;
  assign m1RdData  = rd1_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a round-robin and a fixed-priority instance
// share one stimulus stream, each with its own small memory model.
module tb_data_mem_arbiter;

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] A5 = 32'hA5A5A5A5;
  localparam logic [31:0] W1 = 32'h12345678;
  localparam logic [31:0] P0 = 32'h11111111;
  localparam logic [31:0] P1 = 32'h22222222;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_init = 1'b1;

  logic        m0Req = 1'b0, m0We = 1'b0;
  logic [31:0] m0Addr = '0, m0WtData = '0;
  logic        m1Req = 1'b0, m1We = 1'b0;
  logic [31:0] m1Addr = '0, m1WtData = '0;

  logic        rr_m0Ack, rr_m1Ack, rr_memCe, rr_memWr, rr_busy;
  logic [31:0] rr_m0RdData, rr_m1RdData, rr_memAddr, rr_memWtData, rr_memRdData;
  logic        fp_m0Ack, fp_m1Ack, fp_memCe, fp_memWr, fp_busy;
  logic [31:0] fp_m0RdData, fp_m1RdData, fp_memAddr, fp_memWtData, fp_memRdData;

  logic [31:0] mem_rr [256];
  logic [31:0] mem_fp [256];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst(rst),
    .m0Req(m0Req), .m0We(m0We), .m0Addr(m0Addr), .m0WtData(m0WtData),
    .m0Ack(rr_m0Ack), .m0RdData(rr_m0RdData),
    .m1Req(m1Req), .m1We(m1We), .m1Addr(m1Addr), .m1WtData(m1WtData),
    .m1Ack(rr_m1Ack), .m1RdData(rr_m1RdData),
    .memCe(rr_memCe), .memWr(rr_memWr), .memAddr(rr_memAddr),
    .memWtData(rr_memWtData), .memRdData(rr_memRdData), .busy(rr_busy)
  );

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst(rst),
    .m0Req(m0Req), .m0We(m0We), .m0Addr(m0Addr), .m0WtData(m0WtData),
    .m0Ack(fp_m0Ack), .m0RdData(fp_m0RdData),
    .m1Req(m1Req), .m1We(m1We), .m1Addr(m1Addr), .m1WtData(m1WtData),
    .m1Ack(fp_m1Ack), .m1RdData(fp_m1RdData),
    .memCe(fp_memCe), .memWr(fp_memWr), .memAddr(fp_memAddr),
    .memWtData(fp_memWtData), .memRdData(fp_memRdData), .busy(fp_busy)
  );

  function automatic logic [31:0] init_val(input logic [7:0] a);
    case (a)
      8'h04:   return 32'h00000044;
      8'h08:   return 32'h00000088;
      8'h10:   return DB;
      8'h20:   return 32'h20202020;
      8'h30:   return A5;
      8'h40:   return 32'h40404040;
      default: return 32'h0;
    endcase
  endfunction

  // Memory models: combinational read, write at the edge when enabled
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_rr[i] <= init_val(8'(i));
    end else if (rr_memCe && rr_memWr) begin
      mem_rr[rr_memAddr[7:0]] <= rr_memWtData;
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_fp[i] <= init_val(8'(i));
    end else if (fp_memCe && fp_memWr) begin
      mem_fp[fp_memAddr[7:0]] <= fp_memWtData;
    end
  end

  assign rr_memRdData = mem_rr[rr_memAddr[7:0]];
  assign fp_memRdData = mem_fp[fp_memAddr[7:0]];

  logic [132:0] obs_rr, obs_fp;
  assign obs_rr = {rr_memCe, rr_memWr, rr_m0Ack, rr_m1Ack, rr_busy,
                   rr_memAddr, rr_memWtData, rr_m0RdData, rr_m1RdData};
  assign obs_fp = {fp_memCe, fp_memWr, fp_m0Ack, fp_m1Ack, fp_busy,
                   fp_memAddr, fp_memWtData, fp_m0RdData, fp_m1RdData};

  typedef struct {
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wdata;
    logic        e_ce, e_wr;
    logic [31:0] e_addr, e_wdata;
    logic        e_ack0, e_ack1;
    logic [31:0] e_rd0, e_rd1;
    logic        e_busy;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic m0r, input logic m0w, input logic [31:0] m0a, input logic [31:0] m0d,
    input logic m1r, input logic m1w, input logic [31:0] m1a, input logic [31:0] m1d,
    input logic ce, input logic wr, input logic [31:0] ad, input logic [31:0] wd,
    input logic a0, input logic a1, input logic [31:0] r0, input logic [31:0] r1,
    input logic bz);
    vec_t v;
    v.m0_req = m0r; v.m0_we = m0w; v.m0_addr = m0a; v.m0_wdata = m0d;
    v.m1_req = m1r; v.m1_we = m1w; v.m1_addr = m1a; v.m1_wdata = m1d;
    v.e_ce = ce; v.e_wr = wr; v.e_addr = ad; v.e_wdata = wd;
    v.e_ack0 = a0; v.e_ack1 = a1; v.e_rd0 = r0; v.e_rd1 = r1; v.e_busy = bz;
    return v;
  endfunction

  function automatic logic [132:0] exp_of(input vec_t v);
    return {v.e_ce, v.e_wr, v.e_ack0, v.e_ack1, v.e_busy,
            v.e_addr, v.e_wdata, v.e_rd0, v.e_rd1};
  endfunction

  task automatic check(input string name, input logic [132:0] act, input logic [132:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic apply(input vec_t v);
    m0Req = v.m0_req; m0We = v.m0_we; m0Addr = v.m0_addr; m0WtData = v.m0_wdata;
    m1Req = v.m1_req; m1We = v.m1_we; m1Addr = v.m1_addr; m1WtData = v.m1_wdata;
  endtask

  initial begin
    // Per cycle: inputs for that cycle, then outputs seen in that cycle
    // idle after reset
    vecs[0]  = mk(0,0,32'h0 ,0 , 0,0,32'h0 ,0 , 0,0,32'h00,0 , 0,0,0 ,0 ,0);
    // single m0 read at 0x10
    vecs[1]  = mk(1,0,32'h10,0 , 0,0,32'h0 ,0 , 0,0,32'h00,0 , 0,0,0 ,0 ,0);
    vecs[2]  = mk(1,0,32'h10,0 , 0,0,32'h0 ,0 , 1,0,32'h10,0 , 0,0,0 ,0 ,1);
    vecs[3]  = mk(0,0,32'h10,0 , 0,0,32'h0 ,0 , 0,0,32'h10,0 , 1,0,DB,0 ,1);
    vecs[4]  = mk(0,0,32'h10,0 , 0,0,32'h0 ,0 , 0,0,32'h10,0 , 0,0,DB,0 ,0);
    // single m1 write at 0x20; m1RdData must not change
    vecs[5]  = mk(0,0,32'h10,0 , 1,1,32'h20,W1, 0,0,32'h10,0 , 0,0,DB,0 ,0);
    vecs[6]  = mk(0,0,32'h10,0 , 1,1,32'h20,W1, 1,1,32'h20,W1, 0,0,DB,0 ,1);
    vecs[7]  = mk(0,0,32'h10,0 , 0,1,32'h20,W1, 0,0,32'h20,W1, 0,1,DB,0 ,1);
    vecs[8]  = mk(0,0,32'h10,0 , 0,1,32'h20,W1, 0,0,32'h20,W1, 0,0,DB,0 ,0);
    // contention, both held 12 cycles: grants m0, m1, m0, m1
    vecs[9]  = mk(1,0,32'h30,P0, 1,0,32'h20,P1, 0,0,32'h20,W1, 0,0,DB,0 ,0);
    vecs[10] = mk(1,0,32'h30,P0, 1,0,32'h20,P1, 1,0,32'h30,P0, 0,0,DB,0 ,1);
    vecs[11] = mk(1,0,32'h30,P0, 1,0,32'h20,P1, 0,0,32'h30,P0, 1,0,A5,0 ,1);
    vecs[12] = mk(1,0,32'h30,P0, 1,0,32'h20,P1, 0,0,32'h30,P0, 0,0,A5,0 ,0);
    vecs[13] = mk(1,0,32'h30,P0, 1,0,32'h20,P1, 1,0,32'h20,P1, 0,0,A5,0 ,1);
    vecs[14] = mk(1,0,32'h30,P0, 1,0,32'h20,P1, 0,0,32'h20,P1, 0,1,A5,W1,1);
    vecs[15] = mk(1,0,32'h30,P0, 1,0,32'h20,P1, 0,0,32'h20,P1, 0,0,A5,W1,0);
    vecs[16] = mk(1,0,32'h30,P0, 1,0,32'h20,P1, 1,0,32'h30,P0, 0,0,A5,W1,1);
    vecs[17] = mk(1,0,32'h30,P0, 1,0,32'h20,P1, 0,0,32'h30,P0, 1,0,A5,W1,1);
    vecs[18] = mk(1,0,32'h30,P0, 1,0,32'h20,P1, 0,0,32'h30,P0, 0,0,A5,W1,0);
    vecs[19] = mk(1,0,32'h30,P0, 1,0,32'h20,P1, 1,0,32'h20,P1, 0,0,A5,W1,1);
    vecs[20] = mk(1,0,32'h30,P0, 1,0,32'h20,P1, 0,0,32'h20,P1, 0,1,A5,W1,1);
    vecs[21] = mk(0,0,32'h30,0 , 0,0,32'h20,0 , 0,0,32'h20,P1, 0,0,A5,W1,0);
    // payload change after latch: address moves 0x04 -> 0x08 in ACCESS
    vecs[22] = mk(1,0,32'h04,0 , 0,0,32'h20,0 , 0,0,32'h20,P1, 0,0,A5,W1,0);
    vecs[23] = mk(1,0,32'h08,0 , 0,0,32'h20,0 , 1,0,32'h04,0 , 0,0,A5,W1,1);
    vecs[24] = mk(0,0,32'h08,0 , 0,0,32'h20,0 , 0,0,32'h04,0 , 1,0,32'h44,W1,1);
    vecs[25] = mk(0,0,32'h08,0 , 0,0,32'h20,0 , 0,0,32'h04,0 , 0,0,32'h44,W1,0);

    // Reset and memory preload
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    check("reset_rr", obs_rr, 133'(0));
    check("reset_fp", obs_fp, 133'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    // Table-driven vectors against the round-robin instance
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), obs_rr, exp_of(vecs[i]));
      @(posedge clk); #1;
    end

    // Fixed priority: both held 9 cycles, then m0 drops; m1 served after
    for (int c = 1; c <= 14; c++) begin
      m0Req = (c <= 9);  m0We = 1'b0; m0Addr = 32'h10; m0WtData = '0;
      m1Req = (c <= 12); m1We = 1'b0; m1Addr = 32'h30; m1WtData = '0;
      @(negedge clk);
      check($sformatf("fp_ack_c%0d", c), 133'({fp_m0Ack, fp_m1Ack}),
            133'({(c == 3 || c == 6 || c == 9), (c == 12)}));
      check($sformatf("rr_ack_excl_c%0d", c), 133'(rr_m0Ack & rr_m1Ack), 133'(0));
      if (c == 3)  check("fp_rd0", 133'(fp_m0RdData), 133'(DB));
      if (c == 12) check("fp_rd1", 133'(fp_m1RdData), 133'(A5));
      @(posedge clk); #1;
    end

    // Reset asserted during an m0 write ACCESS
    m0Req = 1'b1; m0We = 1'b1; m0Addr = 32'h40; m0WtData = 32'hCAFEF00D;
    m1Req = 1'b0; m1We = 1'b0; m1Addr = '0; m1WtData = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_access_rr", 133'({rr_memCe, rr_memWr, rr_memAddr}), 133'({2'b11, 32'h40}));
    check("abort_access_fp", 133'({fp_memCe, fp_memWr, fp_memAddr}), 133'({2'b11, 32'h40}));
    #2 rst = 1'b0;
    #1;
    check("abort_async_rr", obs_rr, 133'(0));
    check("abort_async_fp", obs_fp, 133'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_nowrite_rr", 133'(mem_rr[8'h40]), 133'(32'h40404040));
    check("abort_nowrite_fp", 133'(mem_fp[8'h40]), 133'(32'h40404040));
    check("abort_noack_rr", obs_rr, 133'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    m1Req = 1'b1; m1We = 1'b0; m1Addr = 32'h10;

    // Re-issued m0 write wins the first tie after reset, then m1 read
    for (int c = 0; c < 7; c++) begin
      if (c == 2) m0Req = 1'b0;
      if (c == 5) m1Req = 1'b0;
      @(negedge clk);
      check($sformatf("post_rst_rr_c%0d", c), 133'({rr_m0Ack, rr_m1Ack}),
            133'({(c == 2), (c == 5)}));
      check($sformatf("post_rst_fp_c%0d", c), 133'({fp_m0Ack, fp_m1Ack}),
            133'({(c == 2), (c == 5)}));
      if (c == 5) check("post_rst_rd1", 133'(rr_m1RdData), 133'(DB));
      @(posedge clk); #1;
    end
    check("reissue_write_rr", 133'(mem_rr[8'h40]), 133'(32'hCAFEF00D));
    check("reissue_write_fp", 133'(mem_fp[8'h40]), 133'(32'hCAFEF00D));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
